// File: rtl/bundle_sequencer.sv
// Per-bundle loop sequencer: loads descriptors from a register-mapped RAM and walks each
// bundle's loop nest in step with accepted AXIS-out beats, checking o_last and counting errors.
module bundle_sequencer #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned CW             = 16,
    parameter int unsigned N_BUNDLES_MAX  = 8,
    parameter int unsigned N_REG          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reg_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [AXI_DATA_WIDTH-1:0] reg_wr_data,
    output logic                      reg_wr_ack,
    input  logic                      reg_rd_en,
    input  logic [AXI_ADDR_WIDTH-1:0] reg_rd_addr,
    output logic [AXI_DATA_WIDTH-1:0] reg_rd_data,
    output logic                      reg_rd_ack,
    input  logic                      o_valid,
    input  logic                      o_ready,
    input  logic                      o_last,
    output logic                      busy,
    output logic                      irq
);

    localparam int unsigned DEPTH  = 4 * N_BUNDLES_MAX;
    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic [CW-1:0] w_kw2_1, coe_1, n_1, l_1, p_1, t_1, kw;
    } desc_t;

    typedef struct packed {
        logic [CW-1:0] b, p, t, n, l, wk, coe, tail;
    } cnt_t;

    state_t                    state_q, state_d;
    logic [2:0]                ld_cnt_q, ld_cnt_d;
    desc_t                     desc_q, desc_d;
    cnt_t                      cnt_q, cnt_d;
    logic [AXI_DATA_WIDTH-1:0] nb1_q, nb1_d;
    logic [31:0]               beat_cnt_q, beat_cnt_d, err_cnt_q, err_cnt_d;
    logic                      done_q, done_d, err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d, ram_rdata_q, ram_rdata_d;
    logic                      rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;

    logic [AXI_DATA_WIDTH-1:0] ram [DEPTH];

    logic                      ctrl_wr, stat_wr, start_req, abort_req, beat, ram_we;
    logic [AXI_ADDR_WIDTH-1:0] ram_woff;
    logic [RAM_AW-1:0]         ram_waddr, ram_raddr;
    logic [CW-1:0]             tail_max, nb1_eff;
    logic                      wrap_tail, wrap_coe, wrap_wk, wrap_l, wrap_n, wrap_t, wrap_p;
    logic                      unused_ok;

    assign busy        = (state_q == S_LOAD) || (state_q == S_RUN);
    assign irq         = (state_q == S_DONE);
    assign reg_wr_ack  = wr_ack_q;
    assign reg_rd_ack  = rd_ack_q;
    assign reg_rd_data = rd_data_q;
    assign unused_ok   = &{1'b0, ram_rdata_q[AXI_DATA_WIDTH-1:CW]};

    always_comb begin
        ctrl_wr   = reg_wr_en && (reg_wr_addr == AXI_ADDR_WIDTH'(0));
        stat_wr   = reg_wr_en && (reg_wr_addr == AXI_ADDR_WIDTH'(2));
        start_req = ctrl_wr && reg_wr_data[0];
        abort_req = ctrl_wr && reg_wr_data[1];
        beat      = o_valid && o_ready;
        ram_woff  = reg_wr_addr - AXI_ADDR_WIDTH'(N_REG);
        ram_we    = reg_wr_en && (reg_wr_addr >= AXI_ADDR_WIDTH'(N_REG))
                    && (ram_woff < AXI_ADDR_WIDTH'(DEPTH));
        ram_waddr = ram_woff[RAM_AW-1:0];
        ram_raddr = RAM_AW'({cnt_q.b, ld_cnt_q[1:0]});
        ram_rdata_d = ram[ram_raddr];
        nb1_eff   = (nb1_q >= AXI_DATA_WIDTH'(N_BUNDLES_MAX)) ? CW'(N_BUNDLES_MAX - 1)
                                                               : nb1_q[CW-1:0];

        // The kw tail only extends the final w_kw2 iteration; elsewhere it is a single beat.
        tail_max  = (cnt_q.wk == desc_q.w_kw2_1) ? (desc_q.kw >> 1) : '0;
        wrap_tail = (cnt_q.tail == tail_max);
        wrap_coe  = wrap_tail && (cnt_q.coe == desc_q.coe_1);
        wrap_wk   = wrap_coe && (cnt_q.wk == desc_q.w_kw2_1);
        wrap_l    = wrap_wk && (cnt_q.l == desc_q.l_1);
        wrap_n    = wrap_l && (cnt_q.n == desc_q.n_1);
        wrap_t    = wrap_n && (cnt_q.t == desc_q.t_1);
        wrap_p    = wrap_t && (cnt_q.p == desc_q.p_1);
    end

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        desc_d     = desc_q;
        cnt_d      = cnt_q;
        nb1_d      = nb1_q;
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;
        done_d     = done_q;
        err_d      = err_q;
        wr_ack_d   = reg_wr_en;
        rd_ack_d   = reg_rd_en;
        rd_data_d  = '0;

        if (reg_wr_en && (reg_wr_addr == AXI_ADDR_WIDTH'(1))) nb1_d = reg_wr_data;
        if (stat_wr && reg_wr_data[1]) done_d = 1'b0;
        if (stat_wr && reg_wr_data[2]) err_d = 1'b0;

        if (beat && ((state_q != S_RUN) || (o_last != wrap_n))) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d    = S_LOAD;
                    ld_cnt_d   = '0;
                    cnt_d      = '0;
                    beat_cnt_d = '0;
                    err_cnt_d  = '0;
                    done_d     = 1'b0;
                end
            end
            S_LOAD: begin
                ld_cnt_d = ld_cnt_q + 3'd1;
                case (ld_cnt_q)
                    3'd1: {desc_d.w_kw2_1, desc_d.coe_1} = ram_rdata_q[2*CW-1:0];
                    3'd2: {desc_d.n_1, desc_d.l_1}       = ram_rdata_q[2*CW-1:0];
                    3'd3: {desc_d.p_1, desc_d.t_1}       = ram_rdata_q[2*CW-1:0];
                    3'd4: begin
                        desc_d.kw = ram_rdata_q[CW-1:0];
                        state_d   = S_RUN;
                        ld_cnt_d  = '0;
                    end
                    default: ;
                endcase
            end
            S_RUN: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    cnt_d.tail = wrap_tail ? '0 : cnt_q.tail + CW'(1);
                    if (wrap_tail) cnt_d.coe = wrap_coe ? '0 : cnt_q.coe + CW'(1);
                    if (wrap_coe)  cnt_d.wk  = wrap_wk  ? '0 : cnt_q.wk + CW'(1);
                    if (wrap_wk)   cnt_d.l   = wrap_l   ? '0 : cnt_q.l + CW'(1);
                    if (wrap_l)    cnt_d.n   = wrap_n   ? '0 : cnt_q.n + CW'(1);
                    if (wrap_n)    cnt_d.t   = wrap_t   ? '0 : cnt_q.t + CW'(1);
                    if (wrap_t)    cnt_d.p   = wrap_p   ? '0 : cnt_q.p + CW'(1);
                    if (wrap_p) begin
                        if (cnt_q.b == nb1_eff) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d.b  = cnt_q.b + CW'(1);
                            state_d  = S_LOAD;
                            ld_cnt_d = '0;
                        end
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_req) begin
            state_d  = S_IDLE;
            ld_cnt_d = '0;
            cnt_d    = '0;
        end

        if (reg_rd_en) begin
            case (reg_rd_addr)
                AXI_ADDR_WIDTH'(1): rd_data_d = nb1_q;
                AXI_ADDR_WIDTH'(2): rd_data_d = AXI_DATA_WIDTH'({err_q, done_q, busy});
                AXI_ADDR_WIDTH'(3): rd_data_d = AXI_DATA_WIDTH'(beat_cnt_q);
                AXI_ADDR_WIDTH'(4): rd_data_d = AXI_DATA_WIDTH'(err_cnt_q);
                AXI_ADDR_WIDTH'(5): rd_data_d = AXI_DATA_WIDTH'({16'(cnt_q.b), 16'(cnt_q.p)});
                default:            rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ld_cnt_q    <= '0;
            desc_q      <= '0;
            cnt_q       <= '0;
            nb1_q       <= '0;
            beat_cnt_q  <= '0;
            err_cnt_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            ram_rdata_q <= '0;
            rd_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            desc_q      <= desc_d;
            cnt_q       <= cnt_d;
            nb1_q       <= nb1_d;
            beat_cnt_q  <= beat_cnt_d;
            err_cnt_q   <= err_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            ram_rdata_q <= ram_rdata_d;
            rd_ack_q    <= rd_ack_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= reg_wr_data;
    end

endmodule

// File: tb/tb_bundle_sequencer.sv
// Self-checking bench for bundle_sequencer: expected beat counts and o_last positions come
// from closed-form loop-nest arithmetic over randomized descriptors.
module tb_bundle_sequencer;

    localparam int NREG = 16;
    localparam int NBM  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr_en, reg_rd_en, reg_wr_ack, reg_rd_ack;
    logic [31:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
    logic        o_valid, o_ready, o_last, busy, irq;

    int errors = 0;
    int checks = 0;
    int irq_cnt = 0;

    int d_wk[NBM], d_coe[NBM], d_n[NBM], d_l[NBM], d_t[NBM], d_p[NBM], d_kw[NBM];

    bundle_sequencer #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .CW(16),
        .N_BUNDLES_MAX(NBM), .N_REG(NREG)
    ) dut (
        .clk(clk), .rst(rst),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_ack(reg_wr_ack),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .reg_rd_ack(reg_rd_ack),
        .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (irq === 1'b1) irq_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Beats in one (n,l) block; o_last is expected on the final beat of every such block.
    function automatic int blk_len(int b);
        return (d_n[b] + 1) * (d_l[b] + 1) * (d_coe[b] + 1) * (d_wk[b] + 1 + (d_kw[b] >> 1));
    endfunction

    function automatic int bun_len(int b);
        return blk_len(b) * (d_t[b] + 1) * (d_p[b] + 1);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reg_write(input int addr, input logic [31:0] data);
        reg_wr_en = 1'b1; reg_wr_addr = 32'(addr); reg_wr_data = data;
        step();
        reg_wr_en = 1'b0;
    endtask

    task automatic reg_read(input int addr, output logic [31:0] data, output logic ack);
        reg_rd_en = 1'b1; reg_rd_addr = 32'(addr);
        step();
        reg_rd_en = 1'b0;
        data = reg_rd_data;
        ack  = reg_rd_ack;
    endtask

    task automatic set_basic(input int b);
        d_wk[b] = 1; d_coe[b] = 1; d_n[b] = 0; d_l[b] = 0; d_t[b] = 0; d_p[b] = 0; d_kw[b] = 3;
    endtask

    task automatic set_rand(input int b);
        d_wk[b] = $urandom_range(0, 2); d_coe[b] = $urandom_range(0, 2);
        d_n[b]  = $urandom_range(0, 1); d_l[b]   = $urandom_range(0, 1);
        d_t[b]  = $urandom_range(0, 1); d_p[b]   = $urandom_range(0, 1);
        d_kw[b] = $urandom_range(0, 4);
    endtask

    task automatic write_desc(input int b);
        reg_write(NREG + 4*b + 0, {16'(d_wk[b]), 16'(d_coe[b])});
        reg_write(NREG + 4*b + 1, {16'(d_n[b]), 16'(d_l[b])});
        reg_write(NREG + 4*b + 2, {16'(d_p[b]), 16'(d_t[b])});
        reg_write(NREG + 4*b + 3, 32'(d_kw[b]));
    endtask

    // Starts a sequence and feeds every bundle's beats, idling through each 5-cycle load window.
    task automatic run_bundles(input int nb, input bit early, input bit gaps, input bit restart_in_load);
        logic [31:0] rd;
        logic        ack;
        int          len, blk;
        bit          exp_l;
        reg_write(0, 32'h1);
        for (int b = 0; b < nb; b++) begin
            if (b == 0 && restart_in_load) begin
                reg_write(0, 32'h1);
            end else begin
                reg_read(5, rd, ack);
                checks++;
                if (rd !== {16'(b), 16'h0}) begin
                    errors++;
                    $display("FAIL pos_bundle%0d: got %h want %h", b, rd, {16'(b), 16'h0});
                end
            end
            repeat (4) step();
            len = bun_len(b);
            blk = blk_len(b);
            for (int j = 0; j < len; ) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    o_valid = 1'($urandom_range(0, 1));
                    o_ready = !o_valid;
                    o_last  = 1'($urandom_range(0, 1));
                    step();
                end else begin
                    exp_l = ((j + 1) % blk) == 0;
                    if (early && b == 0 && j == blk - 2) exp_l = 1'b1;
                    if (early && b == 0 && j == blk - 1) exp_l = 1'b0;
                    o_valid = 1'b1; o_ready = 1'b1; o_last = exp_l;
                    step();
                    j++;
                end
            end
            o_valid = 1'b0; o_ready = 1'b0; o_last = 1'b0;
        end
        checks++;
        if (irq !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: got irq=%b busy=%b want irq=1 busy=0", irq, busy);
        end
        step();
        checks++;
        if (irq !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got irq=%b busy=%b want irq=0 busy=0", irq, busy);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        ack;
        rst = 1'b1;
        reg_wr_en = 0; reg_rd_en = 0; reg_wr_addr = 0; reg_wr_data = 0; reg_rd_addr = 0;
        o_valid = 0; o_ready = 0; o_last = 0;
        repeat (3) step();
        checks++;
        if ({busy, irq, reg_wr_ack, reg_rd_ack} !== 4'b0 || reg_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b irq=%b wack=%b rack=%b rdata=%h want all 0",
                     busy, irq, reg_wr_ack, reg_rd_ack, reg_rd_data);
        end
        rst = 1'b0;
        step();
        for (int a = 2; a <= 5; a++) begin
            reg_read(a, rd, ack);
            checks++;
            if (rd !== 32'h0 || ack !== 1'b1) begin
                errors++;
                $display("FAIL reset_reg%0d: got data=%h ack=%b want data=0 ack=1", a, rd, ack);
            end
        end
        reg_write(1, 32'h0);
        checks++;
        if (reg_wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_ack: got %b want 1", reg_wr_ack);
        end
        step();
    endtask

    task automatic test_single();
        logic [31:0] rd;
        logic        ack;
        int          irq0;
        set_basic(0);
        write_desc(0);
        reg_write(1, 32'h0);
        irq0 = irq_cnt;
        run_bundles(1, 0, 0, 0);
        reg_read(3, rd, ack);
        checks++;
        if (rd !== 32'd6) begin errors++; $display("FAIL single_beats: got %0d want 6", rd); end
        reg_read(4, rd, ack);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL single_errs: got %0d want 0", rd); end
        reg_read(2, rd, ack);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL single_status: got %h want 2", rd); end
        checks++;
        if (irq_cnt - irq0 != 1) begin
            errors++; $display("FAIL single_irq: got %0d pulses want 1", irq_cnt - irq0);
        end
    endtask

    task automatic test_multi();
        logic [31:0] rd;
        logic        ack;
        int          irq0, total;
        total = 0;
        for (int b = 0; b < 3; b++) begin
            set_rand(b);
            write_desc(b);
            total += bun_len(b);
        end
        reg_write(1, 32'd2);
        irq0 = irq_cnt;
        run_bundles(3, 0, 0, 0);
        reg_read(3, rd, ack);
        checks++;
        if (rd !== 32'(total)) begin errors++; $display("FAIL multi_beats: got %0d want %0d", rd, total); end
        reg_read(4, rd, ack);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL multi_errs: got %0d want 0", rd); end
        checks++;
        if (irq_cnt - irq0 != 1) begin
            errors++; $display("FAIL multi_irq: got %0d pulses want 1", irq_cnt - irq0);
        end
    endtask

    task automatic test_early_last();
        logic [31:0] rd;
        logic        ack;
        int          total;
        set_basic(0);
        set_rand(1);
        set_rand(2);
        total = 0;
        for (int b = 0; b < 3; b++) begin
            write_desc(b);
            total += bun_len(b);
        end
        reg_write(1, 32'd2);
        run_bundles(3, 1, 0, 0);
        reg_read(4, rd, ack);
        checks++;
        if (rd !== 32'd2) begin errors++; $display("FAIL early_errs: got %0d want 2", rd); end
        reg_read(3, rd, ack);
        checks++;
        if (rd !== 32'(total)) begin errors++; $display("FAIL early_beats: got %0d want %0d", rd, total); end
        reg_read(2, rd, ack);
        checks++;
        if (rd !== 32'h6) begin errors++; $display("FAIL early_status: got %h want 6", rd); end
        reg_write(2, 32'h4);
        reg_read(2, rd, ack);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL w1c_err: got %h want 2", rd); end
        reg_write(2, 32'h2);
        reg_read(2, rd, ack);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL w1c_done: got %h want 0", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic        ack;
        int          irq0;
        set_basic(0);
        write_desc(0);
        reg_write(1, 32'h0);
        irq0 = irq_cnt;
        reg_write(0, 32'h1);
        repeat (5) step();
        for (int j = 0; j < 4; j++) begin
            o_valid = 1; o_ready = 1; o_last = 0;
            step();
        end
        o_valid = 0; o_ready = 0;
        reg_write(0, 32'h2);
        checks++;
        if (busy !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got busy=%b irq=%b want 0 0", busy, irq);
        end
        step();
        reg_read(3, rd, ack);
        checks++;
        if (rd !== 32'd4) begin errors++; $display("FAIL abort_beats: got %0d want 4", rd); end
        reg_read(2, rd, ack);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL abort_status: got %h want 0", rd); end
        reg_read(5, rd, ack);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL abort_pos: got %h want 0", rd); end
        checks++;
        if (irq_cnt != irq0) begin errors++; $display("FAIL abort_irq: got %0d pulses want 0", irq_cnt - irq0); end
        reg_write(0, 32'h3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_same: got busy=%b want 0", busy); end
        step();
        run_bundles(1, 0, 0, 0);
        reg_read(3, rd, ack);
        checks++;
        if (rd !== 32'd6) begin errors++; $display("FAIL abort_rerun_beats: got %0d want 6", rd); end
        reg_read(4, rd, ack);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL abort_rerun_errs: got %0d want 0", rd); end
    endtask

    task automatic test_busy_start_idle_beat();
        logic [31:0] rd;
        logic        ack;
        set_basic(0);
        write_desc(0);
        reg_write(1, 32'h0);
        run_bundles(1, 0, 0, 1);
        reg_read(3, rd, ack);
        checks++;
        if (rd !== 32'd6) begin errors++; $display("FAIL busy_start_beats: got %0d want 6", rd); end
        o_valid = 1; o_ready = 1; o_last = 0;
        step();
        o_valid = 0; o_ready = 0;
        step();
        reg_read(4, rd, ack);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL idle_beat_errs: got %0d want 1", rd); end
        reg_read(2, rd, ack);
        checks++;
        if (rd !== 32'h6) begin errors++; $display("FAIL idle_beat_status: got %h want 6", rd); end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] rd;
        logic        ack;
        reg_write(0, 32'h1);
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({busy, irq, reg_wr_ack, reg_rd_ack} !== 4'b0 || reg_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL midload_reset_outputs: got busy=%b irq=%b wack=%b rack=%b rdata=%h want all 0",
                     busy, irq, reg_wr_ack, reg_rd_ack, reg_rd_data);
        end
        rst = 1'b0;
        for (int a = 2; a <= 5; a++) begin
            reg_read(a, rd, ack);
            checks++;
            if (rd !== 32'h0) begin errors++; $display("FAIL midload_reg%0d: got %h want 0", a, rd); end
        end
        reg_write(1, 32'h0);
        run_bundles(1, 0, 0, 0);
        reg_read(3, rd, ack);
        checks++;
        if (rd !== 32'(bun_len(0))) begin
            errors++; $display("FAIL midload_rerun_beats: got %0d want %0d", rd, bun_len(0));
        end
    endtask

    task automatic test_clamp_gaps();
        logic [31:0] rd;
        logic        ack;
        int          total, irq0;
        total = 0;
        for (int b = 0; b < NBM; b++) begin
            set_rand(b);
            write_desc(b);
            total += bun_len(b);
        end
        reg_write(1, 32'(NBM + $urandom_range(0, 100)));
        irq0 = irq_cnt;
        run_bundles(NBM, 0, 1, 0);
        reg_read(3, rd, ack);
        checks++;
        if (rd !== 32'(total)) begin errors++; $display("FAIL clamp_beats: got %0d want %0d", rd, total); end
        reg_read(4, rd, ack);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL clamp_errs: got %0d want 0", rd); end
        checks++;
        if (irq_cnt - irq0 != 1) begin
            errors++; $display("FAIL clamp_irq: got %0d pulses want 1", irq_cnt - irq0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_early_last();
        test_abort();
        test_busy_start_idle_beat();
        test_reset_mid_load();
        test_clamp_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
